debounce_bank: RTL and testbench

Parametrised bank of button/key conditioners for the compy board: synchronises N raw mechanical inputs, debounces each with a configurable stability window, and emits a clean level plus one-cycle press/release events. Adds a per-channel auto-repeat mode (typematic hold delay, then periodic repeat pulses). Sits between board pins and `system`, replacing the per-button single-bit debouncer instances.

---
 rtl/compy_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 125 ++++++++++++
 rtl/debounce_bank.sv | 44 ++++
 tb/tb_debounce_bank.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compy_pkg.sv
// Shared types for the compy board input conditioners: repeat FSM encoding
// and a counter width helper sized from the longest cycle parameter.
package compy_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    // One counter width serves every window: it must hold max(a,b,c)-1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioner: 2-FF synchroniser, polarity normalise, debounce window, typematic repeat.
// Latency: 2 + DEBOUNCE_CYCLES edges from pin change to press/release; no backpressure.
module debounce_channel
    import compy_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    input  logic repeat_en,
    output logic pressed,
    output logic press_evt,
    output logic release_evt,
    output logic repeat_evt
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync;
    logic          lvl;
    logic          differ;
    logic          accept;
    logic          acc_press;
    logic          acc_release;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] rpt_cnt;
    rpt_state_t    state;

    // Resetting to the idle level keeps reset release from looking like a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= {2{IDLE_PIN}};
        end else begin
            sync <= {sync[0], pin};
        end
    end

    always_comb begin
        lvl         = sync[1] ^ IDLE_PIN;
        differ      = (lvl != pressed);
        accept      = differ && (deb_cnt == DEB_LAST);
        acc_press   = accept && !pressed;
        acc_release = accept && pressed;
    end

    // Any agreeing cycle wipes the count, so glitches earn no partial credit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt     <= '0;
            pressed     <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            press_evt   <= acc_press;
            release_evt <= acc_release;
            if (!differ) begin
                deb_cnt <= '0;
            end else if (accept) begin
                deb_cnt <= '0;
                pressed <= ~pressed;
            end else begin
                deb_cnt <= deb_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RPT_IDLE;
            rpt_cnt    <= '0;
            repeat_evt <= 1'b0;
        end else begin
            repeat_evt <= 1'b0;
            if (acc_release) begin
                // Release wins over a coincident repeat expiry.
                state   <= RPT_IDLE;
                rpt_cnt <= '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (acc_press) begin
                            state   <= RPT_DELAY;
                            rpt_cnt <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (!repeat_en) begin
                            rpt_cnt <= '0;
                        end else if (rpt_cnt == RD_LAST) begin
                            repeat_evt <= 1'b1;
                            rpt_cnt    <= '0;
                            state      <= RPT_REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt + CW'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!repeat_en) begin
                            rpt_cnt <= '0;
                            state   <= RPT_DELAY;
                        end else if (rpt_cnt == RP_LAST) begin
                            repeat_evt <= 1'b1;
                            rpt_cnt    <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + CW'(1);
                        end
                    end
                    default: begin
                        state   <= RPT_IDLE;
                        rpt_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce/auto-repeat channels between board pins and the system.
// Latency: 2 + DEBOUNCE_CYCLES edges per accepted level change; no backpressure.
module debounce_bank
    import compy_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] pins,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_evt,
    output logic [CHANNELS-1:0] release_evt,
    output logic [CHANNELS-1:0] repeat_evt,
    output logic                any_pressed
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .pin         (pins[g]),
            .repeat_en   (repeat_en[g]),
            .pressed     (pressed[g]),
            .press_evt   (press_evt[g]),
            .release_evt (release_evt[g]),
            .repeat_evt  (repeat_evt[g])
        );
    end

    // Derived only from registered levels, so nothing from pins reaches it combinationally.
    assign any_pressed = |pressed;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random pin/enable activity
// checked against a cycle-level behavioural model.
module tb_debounce_bank;

    localparam int CH  = 3;
    localparam int AL  = 1;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam logic AL_BIT = (AL != 0);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] pins = '1;
    logic [CH-1:0] repeat_en = '0;
    logic [CH-1:0] pressed, press_evt, release_evt, repeat_evt;
    logic          any_pressed;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    debounce_bank #(
        .CHANNELS        (CH),
        .ACTIVE_LOW      (AL),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pins        (pins),
        .repeat_en   (repeat_en),
        .pressed     (pressed),
        .press_evt   (press_evt),
        .release_evt (release_evt),
        .repeat_evt  (repeat_evt),
        .any_pressed (any_pressed)
    );

    // Reference model: pins seen two edges late; a level is accepted after DEB
    // consecutive disagreeing edges; repeats fire when the count of consecutive
    // enabled held edges k satisfies k >= RD and (k - RD) % RP == 0.
    logic [CH-1:0] h1, h2, m_pressed, m_pevt, m_revt, m_rpt;
    int            run[CH];
    int            k[CH];

    task automatic model_step();
        logic lvl;
        if (!reset_n) begin
            h1 = '1; h2 = '1;
            m_pressed = '0; m_pevt = '0; m_revt = '0; m_rpt = '0;
            for (int c = 0; c < CH; c++) begin
                run[c] = 0;
                k[c] = 0;
            end
        end else begin
            m_pevt = '0; m_revt = '0; m_rpt = '0;
            for (int c = 0; c < CH; c++) begin
                lvl = h2[c] ^ AL_BIT;
                if (lvl != m_pressed[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DEB) begin
                        m_pressed[c] = lvl;
                        run[c] = 0;
                        if (lvl) m_pevt[c] = 1'b1;
                        else     m_revt[c] = 1'b1;
                    end
                end else begin
                    run[c] = 0;
                end
                if (m_pevt[c] || m_revt[c]) begin
                    k[c] = 0;
                end else if (m_pressed[c]) begin
                    if (repeat_en[c]) begin
                        k[c] = k[c] + 1;
                        if (k[c] >= RD && (k[c] - RD) % RP == 0) m_rpt[c] = 1'b1;
                    end else begin
                        k[c] = 0;
                    end
                end
            end
            h2 = h1;
            h1 = pins;
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    wire  [4*CH:0] obs_vec = {pressed, press_evt, release_evt, repeat_evt, any_pressed};
    logic [4*CH:0] exp_vec;
    assign exp_vec = {m_pressed, m_pevt, m_revt, m_rpt, |m_pressed};

    task automatic test_reset();
        reset_n = 1'b0;
        pins = '1;
        repeat_en = '0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (obs_vec !== '0) begin
            err_cnt++;
            $display("FAIL reset_hold got=%b want=0", obs_vec);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== '0) begin
                err_cnt++;
                $display("FAIL reset_idle i=%0d got=%b want=0", i, obs_vec);
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL reset_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_press();
        @(negedge clk);
        pins[0] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (pressed[0] !== (i >= 6) || press_evt[0] !== (i == 6) || any_pressed !== (i >= 6)) begin
                err_cnt++;
                $display("FAIL press_latency i=%0d got p=%b e=%b any=%b want p=%b e=%b",
                         i, pressed[0], press_evt[0], any_pressed, i >= 6, i == 6);
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL press_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
        pins[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL press_release_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== '0) begin
                err_cnt++;
                $display("FAIL glitch_reject i=%0d got=%b want=0", i, obs_vec);
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL glitch_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            pins[1] = (i >= 20) ? 1'b1 : ((i % 4) == 3);
        end
    endtask

    task automatic test_repeat();
        for (int i = 0; i <= 55; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                vec_cnt++;
                if (repeat_evt[2] !== (i >= 16 && i < 43 && (i - 16) % 3 == 0) ||
                    release_evt[2] !== (i == 43) || press_evt[2] !== (i == 6)) begin
                    err_cnt++;
                    $display("FAIL repeat_timing i=%0d got rpt=%b rel=%b prs=%b", i,
                             repeat_evt[2], release_evt[2], press_evt[2]);
                end
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL repeat_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i == 0) begin
                pins[2] = 1'b0;
                repeat_en[2] = 1'b1;
            end
            if (i == 37) pins[2] = 1'b1;
        end
        repeat_en = '0;
    endtask

    task automatic test_en_toggle();
        for (int i = 0; i <= 52; i++) begin
            @(negedge clk);
            if (i >= 1) begin
                vec_cnt++;
                if (repeat_evt[0] !== (i >= 28 && i < 46 && (i - 28) % 3 == 0) ||
                    release_evt[0] !== (i == 46)) begin
                    err_cnt++;
                    $display("FAIL en_toggle i=%0d got rpt=%b rel=%b", i, repeat_evt[0], release_evt[0]);
                end
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL en_toggle_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            if (i == 0) begin
                pins[0] = 1'b0;
                repeat_en[0] = 1'b1;
            end
            if (i == 13) repeat_en[0] = 1'b0;
            if (i == 18) repeat_en[0] = 1'b1;
            if (i == 40) pins[0] = 1'b1;
        end
        repeat_en = '0;
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        pins[1:0] = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL midhold_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        vec_cnt++;
        if (obs_vec !== '0) begin
            err_cnt++;
            $display("FAIL midhold_async_clear got=%b want=0", obs_vec);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            vec_cnt++;
            if (press_evt[1:0] !== ((j == 6) ? 2'b11 : 2'b00) ||
                pressed[1:0] !== ((j >= 6) ? 2'b11 : 2'b00)) begin
                err_cnt++;
                $display("FAIL midhold_refire j=%0d got evt=%b p=%b", j, press_evt[1:0], pressed[1:0]);
            end
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL midhold_refire_model j=%0d got=%b want=%b", j, obs_vec, exp_vec);
            end
        end
        pins = '1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL midhold_release_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int hold[CH];
        for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 25);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL random_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
            for (int c = 0; c < CH; c++) begin
                if (hold[c] == 0) begin
                    pins[c] = ~pins[c];
                    hold[c] = $urandom_range(1, 25);
                end else begin
                    hold[c] = hold[c] - 1;
                end
                if ($urandom_range(0, 15) == 0) repeat_en[c] = ~repeat_en[c];
            end
        end
        pins = '1;
        repeat_en = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (obs_vec !== exp_vec) begin
                err_cnt++;
                $display("FAIL random_settle_model i=%0d got=%b want=%b", i, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_repeat();
        test_en_toggle();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
